// File: rtl/spi_display_pkg.sv
// rtl/spi_display_pkg.sv - shared opcodes, window defaults, pixel format and decoder states
package spi_display_pkg;

  localparam logic [7:0] CASET_OP = 8'h2A;
  localparam logic [7:0] PASET_OP = 8'h2B;
  localparam logic [7:0] RAMWR_OP = 8'h2C;

  localparam int DEF_XE = 239;
  localparam int DEF_YE = 319;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  typedef logic [RGB_W-1:0] rgb565_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_display_monitor_if.sv
// rtl/spi_display_monitor_if.sv - SPI panel pins and decoded byte/pixel events
interface spi_display_monitor_if #(
  parameter int COORD_W = 9
);
  import spi_display_pkg::*;

  logic               i_sclk;
  logic               i_mosi;
  logic               i_dc;
  logic               i_cs;
  logic               o_byte_valid;
  logic [7:0]         o_byte;
  logic               o_byte_dc;
  logic               o_px_valid;
  logic [COORD_W-1:0] o_px_x;
  logic [COORD_W-1:0] o_px_y;
  rgb565_t            o_px_color;
  logic               o_err;

  modport master (
    output i_sclk, i_mosi, i_dc, i_cs,
    input  o_byte_valid, o_byte, o_byte_dc, o_px_valid, o_px_x, o_px_y, o_px_color, o_err
  );

  modport slave (
    input  i_sclk, i_mosi, i_dc, i_cs,
    output o_byte_valid, o_byte, o_byte_dc, o_px_valid, o_px_x, o_px_y, o_px_color, o_err
  );

endinterface

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - oversampling SPI mode-0 byte receiver
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic       i_cs,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       byte_dc,
  output logic       cs_abort
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] dc_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic                   sclk_d;
  logic                   cs_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;

  logic sclk_s, mosi_s, dc_s, cs_s;
  logic sclk_rise, cs_rise;

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign dc_s   = dc_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign cs_rise   = cs_s & ~cs_d;

  // Byte events are combinational so the decoder can register byte and pixel pulses together.
  assign byte_valid = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte    = {shreg, mosi_s};
  assign byte_dc    = dc_s;
  assign cs_abort   = cs_rise && (bit_cnt != 3'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      dc_sr   <= '0;
      cs_sr   <= '1;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], i_sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], i_mosi};
      dc_sr   <= {dc_sr[SYNC_STAGES-2:0], i_dc};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], i_cs};
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
      if (cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/spi_display_monitor.sv
// rtl/spi_display_monitor.sv - CASET/PASET/RAMWR decoder emitting one event per RGB565 pixel
module spi_display_monitor
  import spi_display_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         COORD_W     = 9,
  parameter logic [7:0] CMD_CASET   = CASET_OP,
  parameter logic [7:0] CMD_PASET   = PASET_OP,
  parameter logic [7:0] CMD_RAMWR   = RAMWR_OP
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  spi_display_monitor_if.slave  bus
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       rx_abort;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sclk     (bus.i_sclk),
    .i_mosi     (bus.i_mosi),
    .i_dc       (bus.i_dc),
    .i_cs       (bus.i_cs),
    .byte_valid (rx_valid),
    .rx_byte    (rx_byte),
    .byte_dc    (rx_dc),
    .cs_abort   (rx_abort)
  );

  state_t             state;
  logic [1:0]         param_idx;
  logic [23:0]        param_buf;
  logic               phase;
  logic [7:0]         hi_byte;
  logic [COORD_W-1:0] xs, xe, ys, ye;
  logic [COORD_W-1:0] x, y;

  logic [15:0] win_start;
  logic [15:0] win_end;
  logic        unused_win_bits;

  assign win_start       = param_buf[23:8];
  assign win_end         = {param_buf[7:0], rx_byte};
  assign unused_win_bits = ^{win_start, win_end};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      param_idx        <= 2'd0;
      param_buf        <= 24'd0;
      phase            <= 1'b0;
      hi_byte          <= 8'd0;
      xs               <= '0;
      xe               <= COORD_W'(DEF_XE);
      ys               <= '0;
      ye               <= COORD_W'(DEF_YE);
      x                <= '0;
      y                <= '0;
      bus.o_byte_valid <= 1'b0;
      bus.o_byte       <= 8'd0;
      bus.o_byte_dc    <= 1'b0;
      bus.o_px_valid   <= 1'b0;
      bus.o_px_x       <= '0;
      bus.o_px_y       <= '0;
      bus.o_px_color   <= '0;
      bus.o_err        <= 1'b0;
    end else begin
      bus.o_byte_valid <= rx_valid;
      bus.o_px_valid   <= 1'b0;
      if (rx_abort) begin
        bus.o_err <= 1'b1;
      end
      if (rx_valid) begin
        bus.o_byte    <= rx_byte;
        bus.o_byte_dc <= rx_dc;
        if (!rx_dc) begin
          // Leaving CASET/PASET before the last parameter drops the half-written window.
          if (state == ST_CASET || state == ST_PASET) begin
            bus.o_err <= 1'b1;
          end
          param_idx <= 2'd0;
          if (rx_byte == CMD_CASET) begin
            state <= ST_CASET;
          end else if (rx_byte == CMD_PASET) begin
            state <= ST_PASET;
          end else if (rx_byte == CMD_RAMWR) begin
            state <= ST_RAMWR;
            x     <= xs;
            y     <= ys;
            phase <= 1'b0;
          end else begin
            state <= ST_IGNORE;
          end
        end else begin
          case (state)
            ST_CASET, ST_PASET: begin
              if (param_idx == 2'd3) begin
                if (state == ST_CASET) begin
                  xs <= win_start[COORD_W-1:0];
                  xe <= win_end[COORD_W-1:0];
                end else begin
                  ys <= win_start[COORD_W-1:0];
                  ye <= win_end[COORD_W-1:0];
                end
                state <= ST_IDLE;
              end else begin
                param_buf <= {param_buf[15:0], rx_byte};
                param_idx <= param_idx + 2'd1;
              end
            end
            ST_RAMWR: begin
              if (!phase) begin
                hi_byte <= rx_byte;
                phase   <= 1'b1;
              end else begin
                phase          <= 1'b0;
                bus.o_px_valid <= 1'b1;
                bus.o_px_x     <= x;
                bus.o_px_y     <= y;
                bus.o_px_color <= {hi_byte, rx_byte};
                // Equality-only wrap lets degenerate windows roll over the full coordinate range.
                if (x == xe) begin
                  x <= xs;
                  y <= (y == ye) ? ys : y + 1'b1;
                end else begin
                  x <= x + 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/spi_display_monitor.md
Name: spi_display_monitor

Overview:
- Receive-side model of the SPI display panel driven by our SPI drawing engines (pentagon, line, Petersen-graph blocks).
- Samples SCLK/MOSI/DC/CS, assembles bytes, and decodes the ILI9341-style command subset CASET/PASET/RAMWR.
- Emits one pixel-write event per RGB565 pixel, so benches and on-chip checkers can rebuild the drawn frame.
- Fully synchronous to the system clock; SPI pins are oversampled, so the system clock must be at least 4x SCLK.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection (minimum 2).
- COORD_W, 9, width of the X/Y coordinate outputs; upper bits of 16-bit coordinates are truncated.
- CMD_CASET, 8'h2A, column address set opcode.
- CMD_PASET, 8'h2B, page address set opcode.
- CMD_RAMWR, 8'h2C, memory write opcode.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sclk  in  1  SPI clock; mode 0, data sampled on the rising edge.
- i_mosi  in  1  SPI data, MSB first.
- i_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
- i_cs  in  1  chip select, active low.
- o_byte_valid  out  1  one-cycle pulse when a full byte has been received.
- o_byte  out  8  received byte; held until the next pulse.
- o_byte_dc  out  1  DC value that accompanied o_byte.
- o_px_valid  out  1  one-cycle pulse per completed pixel.
- o_px_x  out  COORD_W  column of the pixel.
- o_px_y  out  COORD_W  page (row) of the pixel.
- o_px_color  out  16  RGB565 value, first data byte in [15:8].
- o_err  out  1  sticky; set when CS rises mid-byte or mid-parameter. Cleared only by i_rst.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - All outputs go to 0.
  - Synchronizers are loaded with idle values: sclk=0, cs=1.
  - Bit count is 0; FSM goes to IDLE.
  - Window registers become XS=0, XE=239, YS=0, YE=319.
  - Reset while a transfer is in progress discards it.
- Edge detection: an SCLK rise is sync_sclk=1 while the delayed copy is 0, qualified by synchronized CS=0.
- Shift register:
  - On each SCLK rise, shift in MOSI, MSB first, and increment a 3-bit count.
  - On the 8th bit, in the same cycle: o_byte_valid=1, o_byte=assembled byte, o_byte_dc=DC synchronized at that edge.
  - Latency from raw SCLK edge to the o_byte_valid pulse is SYNC_STAGES+1 clocks.
- CS deassert:
  - Synchronized CS rising clears the bit count, and the partial byte is dropped.
  - If the count was nonzero, set o_err.
  - The FSM keeps its state, so RAMWR may continue across CS toggles, matching panel behaviour.
- Decoder FSM: states IDLE, CASET, PASET, RAMWR, IGNORE.
  - Any command byte (dc=0) in any state aborts the current command and selects the next state:
    - CMD_CASET -> CASET, parameter index 0.
    - CMD_PASET -> PASET, parameter index 0.
    - CMD_RAMWR -> RAMWR; current pixel is set to (XS, YS) and the byte phase is cleared.
    - Any other opcode -> IGNORE.
  - CASET/PASET take 4 data bytes: start hi, start lo, end hi, end lo.
    - Window registers are committed only after the 4th byte; then the FSM returns to IDLE.
    - A command arriving before the 4th byte leaves the old window intact and sets o_err.
  - RAMWR: data bytes alternate hi/lo. On the lo byte:
    - o_px_valid pulses in the same cycle as that byte's o_byte_valid.
    - Pixel fields are the current x, current y, and {hi, lo}.
    - The address then advances: x = (x == XE) ? XS : x+1. When x wraps, y = (y == YE) ? YS : y+1.
  - Data bytes received in IDLE or IGNORE produce o_byte_valid only.
- Degenerate windows: XS > XE or YS > YE is accepted. The wrap test is equality only, so the coordinate counter wraps modulo 2^COORD_W until it hits the end value.

Decomposition:
- Shared package spi_display_pkg:
  - Opcodes CMD_CASET/PASET/RAMWR.
  - FSM state encoding.
  - Default window constants (239, 319).
  - RGB565 field widths.
- One sub-module: spi_byte_rx.
  - Contains the synchronizers, edge detect, shift register and bit count.
  - Outputs byte_valid, byte, dc and cs_abort.
- The decoder FSM and address counter live in spi_display_monitor.

Test Plan:
- Byte: CS low, shift 0xA5 with DC=1 at SCLK = clk/4 -> one o_byte_valid, o_byte=8'hA5, o_byte_dc=1, SYNC_STAGES+1 clocks after the 8th rising edge.
- Window and pixels: 2A 00 0A 00 0B, then 2B 00 05 00 05, then 2C plus 3 pixels F8 00 07 E0 00 1F -> pixels (10,5,F800), (11,5,07E0), (10,5,001F).
- Wrap: CASET 0..1, PASET 0..1, RAMWR 5 pixels -> coordinates (0,0), (1,0), (0,1), (1,1), (0,0).
- Abort: CS rises after 3 bits -> no byte pulse, o_err=1. The next full byte 0x3C is received correctly.
- Interrupted CASET: 2A 00 0A followed by 2C -> window stays 0..239, o_err=1, first pixel at (0,0).
- Reset mid-RAMWR: i_rst after a hi byte -> all outputs 0. The next lo byte alone produces no o_px_valid.
